// File: rtl/mem_data_bridge_if.sv
// rtl/mem_data_bridge_if.sv - data-side SRAM-like bus between the MEM stage and memory
//
// Signals:
//   data_req     request, driven by the bridge (address phase)
//   data_wr      1 = write
//   data_size    00 byte, 01 half, 10 word
//   data_addr    physical byte address
//   data_wdata   lane-replicated store data
//   data_addr_ok address phase accepted, driven by memory
//   data_data_ok data phase complete, driven by memory
//   data_rdata   read data in word-aligned lanes
interface mem_data_bridge_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_data_bridge.sv
// rtl/mem_data_bridge.sv - MEM-stage data access unit driving the SRAM-like data bus
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   exception                pipeline flush request
//   mem_ram_read_enable      load present in MEM
//   mem_ram_write_enable     store present in MEM (wins over read)
//   mem_access_size          00 byte, 01 half, 10/11 word
//   mem_load_signed          sign-extend load result
//   mem_ram_addr             virtual byte address
//   mem_ram_write_data       right-aligned store data
//   data_stall               freeze EX/MEM and earlier stages
//   mem_load_data            extended load result, held until the next completed load
//   addr_error_load/_store   misaligned access flags
//   bus                      data bus, master side
module mem_data_bridge #(
    parameter int unsigned KSEG_STRIP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception,
    input  logic        mem_ram_read_enable,
    input  logic        mem_ram_write_enable,
    input  logic [1:0]  mem_access_size,
    input  logic        mem_load_signed,
    input  logic [31:0] mem_ram_addr,
    input  logic [31:0] mem_ram_write_data,
    output logic        data_stall,
    output logic [31:0] mem_load_data,
    output logic        addr_error_load,
    output logic        addr_error_store,
    mem_data_bridge_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] load_q, load_d;

    logic        access;
    logic        is_load;
    logic        misaligned;
    logic        valid;
    logic        req_raw;
    logic        stall_raw;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;

    assign access  = mem_ram_read_enable | mem_ram_write_enable;
    assign is_load = mem_ram_read_enable & ~mem_ram_write_enable;

    always_comb begin
        misaligned = 1'b0;
        case (mem_access_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mem_ram_addr[0];
            default: misaligned = (mem_ram_addr[1:0] != 2'b00);
        endcase
    end

    assign valid            = access & ~misaligned & ~exception;
    assign addr_error_load  = is_load & misaligned;
    assign addr_error_store = mem_ram_write_enable & misaligned;

    // Bus side: address/size/data always follow the current MEM inputs,
    // which the stall keeps stable for the whole transaction.
    assign bus.data_size = (mem_access_size == 2'b11) ? 2'b10 : mem_access_size;
    assign bus.data_addr = ((KSEG_STRIP != 0) && (mem_ram_addr[31:30] == 2'b10))
                         ? {3'b000, mem_ram_addr[28:0]} : mem_ram_addr;

    always_comb begin
        bus.data_wdata = mem_ram_write_data;
        case (mem_access_size)
            2'b00:   bus.data_wdata = {4{mem_ram_write_data[7:0]}};
            2'b01:   bus.data_wdata = {2{mem_ram_write_data[15:0]}};
            default: bus.data_wdata = mem_ram_write_data;
        endcase
    end

    // Load extraction from word-aligned read lanes
    always_comb begin
        byte_lane = bus.data_rdata[7:0];
        case (mem_ram_addr[1:0])
            2'b00: byte_lane = bus.data_rdata[7:0];
            2'b01: byte_lane = bus.data_rdata[15:8];
            2'b10: byte_lane = bus.data_rdata[23:16];
            2'b11: byte_lane = bus.data_rdata[31:24];
        endcase
        half_lane = mem_ram_addr[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        load_ext  = bus.data_rdata;
        case (mem_access_size)
            2'b00:   load_ext = {{24{mem_load_signed & byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = {{16{mem_load_signed & half_lane[15]}}, half_lane};
            default: load_ext = bus.data_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            load_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        req_raw   = 1'b0;
        stall_raw = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_raw   = valid;
                stall_raw = valid;
                if (valid)
                    state_d = bus.data_addr_ok ? S_WAIT : S_REQ;
            end
            S_REQ: begin
                req_raw   = 1'b1;
                stall_raw = 1'b1;
                // An accepted address commits us to a data phase, flush or not.
                if (bus.data_addr_ok)
                    state_d = exception ? S_DRAIN : S_WAIT;
                else if (exception)
                    state_d = S_IDLE;
            end
            S_WAIT: begin
                stall_raw = 1'b1;
                if (bus.data_data_ok) begin
                    if (exception) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        if (is_load)
                            load_d = load_ext;
                    end
                end else if (exception) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                // Flushed transaction still in flight; hold any new access off.
                stall_raw = access;
                if (bus.data_data_ok)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.data_req  = req_raw & ~rst;
    assign bus.data_wr   = mem_ram_write_enable & ~rst;
    assign data_stall    = stall_raw & ~rst;
    assign mem_load_data = load_q;

endmodule

// File: tb/tb_mem_data_bridge.sv
// tb/tb_mem_data_bridge.sv - self-checking bench for mem_data_bridge
module tb_mem_data_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        exception;
    logic        re, we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr, wdata;
    logic        data_stall;
    logic [31:0] mem_load_data;
    logic        addr_error_load, addr_error_store;

    mem_data_bridge_if bus();

    mem_data_bridge #(.KSEG_STRIP(1)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .exception            (exception),
        .mem_ram_read_enable  (re),
        .mem_ram_write_enable (we),
        .mem_access_size      (sz),
        .mem_load_signed      (sg),
        .mem_ram_addr         (addr),
        .mem_ram_write_data   (wdata),
        .data_stall           (data_stall),
        .mem_load_data        (mem_load_data),
        .addr_error_load      (addr_error_load),
        .addr_error_store     (addr_error_store),
        .bus                  (bus.master)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_load = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_load(input logic [1:0] s, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * a[1:0]);
        if (s == 2'b00) return (sgn && sh[7])  ? (32'hFFFF_FF00 | (sh & 32'hFF))   : (sh & 32'hFF);
        if (s == 2'b01) return (sgn && sh[15]) ? (32'hFFFF_0000 | (sh & 32'hFFFF)) : (sh & 32'hFFFF);
        return rd;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] s, input logic [31:0] d);
        if (s == 2'b00) return {4{d[7:0]}};
        if (s == 2'b01) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] exp_paddr(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
        return a;
    endfunction

    // One MEM-stage instruction: address phase after a_dly refused cycles,
    // data phase after d_dly empty cycles, then the DONE cycle.
    task automatic do_access(input logic r, input logic w, input logic [1:0] s, input logic sgn,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int a_dly, input int d_dly);
        logic mis;
        re = r; we = w; sz = s; sg = sgn; addr = a; wdata = wd; exception = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        mis = (s == 2'b01 && a[0]) || (s[1] && a[1:0] != 2'b00);
        if (!(r || w)) begin
            bus.data_data_ok = ($urandom_range(0, 1) == 1);
            bus.data_rdata   = $urandom;
            #1;
            chk("idle_req", bus.data_req, 0);
            chk("idle_stall", data_stall, 0);
            step();
            bus.data_data_ok = 1'b0;
            return;
        end
        #1;
        chk("err_load", addr_error_load, r && !w && mis);
        chk("err_store", addr_error_store, w && mis);
        if (mis) begin
            chk("mis_req", bus.data_req, 0);
            chk("mis_stall", data_stall, 0);
            step();
            return;
        end
        for (int i = 0; i <= a_dly; i++) begin
            bus.data_addr_ok = (i == a_dly);
            #1;
            chk("aph_req", bus.data_req, 1);
            chk("aph_stall", data_stall, 1);
            if (i == a_dly) begin
                chk("aph_addr", bus.data_addr, exp_paddr(a));
                chk("aph_size", bus.data_size, (s == 2'b11) ? 2'b10 : s);
                chk("aph_wr", bus.data_wr, w);
                if (w) chk("aph_wdata", bus.data_wdata, exp_wdata(s, wd));
            end
            step();
        end
        bus.data_addr_ok = 1'b0;
        for (int i = 0; i <= d_dly; i++) begin
            bus.data_data_ok = (i == d_dly);
            bus.data_rdata   = (i == d_dly) ? rd : $urandom;
            #1;
            chk("dph_req", bus.data_req, 0);
            chk("dph_stall", data_stall, 1);
            step();
        end
        bus.data_data_ok = 1'b0;
        if (r && !w) last_load = exp_load(s, sgn, a, rd);
        chk("done_stall", data_stall, 0);
        chk("done_req", bus.data_req, 0);
        chk("done_load", mem_load_data, last_load);
        step();
    endtask

    initial begin
        rst = 1'b1; exception = 1'b0; re = 1'b0; we = 1'b0; sz = 2'b10; sg = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        re = 1'b1;
        #12;
        chk("rst_req", bus.data_req, 0);
        chk("rst_stall", data_stall, 0);
        chk("rst_wr", bus.data_wr, 0);
        chk("rst_load", mem_load_data, 0);
        re = 1'b0;
        step();
        rst = 1'b0;
        step();

        do_access(1, 0, 2'b10, 0, 32'h8000_0010, 32'h0, 32'h1234_5678, 0, 0);
        do_access(1, 0, 2'b00, 1, 32'h0000_0003, 32'h0, 32'h80FF_FF7F, 0, 0);
        chk("lb_signed", mem_load_data, 32'hFFFF_FF80);
        do_access(1, 0, 2'b00, 0, 32'h0000_0003, 32'h0, 32'h80FF_FF7F, 1, 2);
        chk("lbu", mem_load_data, 32'h0000_0080);
        do_access(1, 0, 2'b01, 1, 32'h0000_0002, 32'h0, 32'hBEEF_0000, 0, 1);
        chk("lh_signed", mem_load_data, 32'hFFFF_BEEF);
        do_access(0, 1, 2'b00, 0, 32'h0000_0001, 32'h0000_00AB, 32'h0, 3, 0);
        do_access(1, 0, 2'b10, 0, 32'h0000_0002, 32'h0, 32'h0, 0, 0);
        do_access(0, 1, 2'b01, 0, 32'h0000_0001, 32'h0, 32'h0, 0, 0);

        // Flush while waiting for data: drain, stale data discarded, next load held off
        re = 1'b1; we = 1'b0; sz = 2'b10; sg = 1'b0; addr = 32'h40;
        bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0;
        exception = 1'b1;
        #1;
        chk("exw_stall", data_stall, 1);
        chk("exw_req", bus.data_req, 0);
        step();
        exception = 1'b0; addr = 32'h44;
        for (int i = 0; i < 3; i++) begin
            bus.data_data_ok = (i == 2);
            bus.data_rdata   = 32'hDEAD_BEEF;
            #1;
            chk("drain_req", bus.data_req, 0);
            chk("drain_stall", data_stall, 1);
            step();
        end
        bus.data_data_ok = 1'b0;
        chk("drain_load_kept", mem_load_data, last_load);
        do_access(1, 0, 2'b10, 0, 32'h44, 32'h0, 32'h0BAD_F00D, 0, 0);

        // Flush in the address phase with address accepted: must drain
        re = 1'b1; addr = 32'h48;
        #1;
        step();
        exception = 1'b1; bus.data_addr_ok = 1'b1;
        #1;
        chk("exr_req", bus.data_req, 1);
        step();
        exception = 1'b0; bus.data_addr_ok = 1'b0;
        #1;
        chk("exr_drain_req", bus.data_req, 0);
        chk("exr_drain_stall", data_stall, 1);
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5555_AAAA;
        step();
        bus.data_data_ok = 1'b0;
        chk("exr_load_kept", mem_load_data, last_load);

        // Flush in the address phase without acceptance: request dropped
        re = 1'b1; addr = 32'h4C;
        step();
        exception = 1'b1;
        step();
        exception = 1'b0; re = 1'b0;
        #1;
        chk("exd_req", bus.data_req, 0);
        chk("exd_stall", data_stall, 0);
        step();

        for (int n = 0; n < 200; n++) begin
            int          kind;
            logic [1:0]  rs;
            logic [31:0] ra;
            kind = $urandom_range(0, 6);
            rs   = 2'($urandom_range(0, 3));
            ra   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rs == 2'b01) ra[0] = 1'b0;
                if (rs[1]) ra[1:0] = 2'b00;
            end
            do_access((kind <= 2) || (kind == 5), (kind == 3) || (kind == 4) || (kind == 5),
                      rs, 1'($urandom_range(0, 1)), ra, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3));
            if (kind == 6) chk("hold_load", mem_load_data, last_load);
        end

        // Asynchronous reset while waiting for data
        do_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hCAFE_0001, 0, 0);
        re = 1'b1; addr = 32'h104; bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0;
        #1;
        chk("prerst_stall", data_stall, 1);
        rst = 1'b1;
        #1;
        chk("arst_req", bus.data_req, 0);
        chk("arst_stall", data_stall, 0);
        chk("arst_load", mem_load_data, 0);
        last_load = 32'h0;
        re = 1'b0;
        step();
        rst = 1'b0;
        step();
        do_access(1, 0, 2'b01, 0, 32'h0000_0006, 32'h0, 32'h9876_0000, 2, 1);
        chk("post_rst_lhu", mem_load_data, 32'h0000_9876);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
